imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, RAM word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 The module SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive lost arbitrations before the loader is forced.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port f_req, input, 1, fetch read request, held until granted.
REQ-007 The module SHALL have port f_addr, input, ADDR_WIDTH, fetch address, stable while f_req is high.
REQ-008 The module SHALL have ports f_gnt and f_rvalid, output, 1 each: fetch accept pulse and fetch read-data-valid pulse.
REQ-009 The module SHALL have port l_req, input, 1, loader request, held until granted.
REQ-010 The module SHALL have ports l_we (input, 1, 1=write), l_addr (input, ADDR_WIDTH) and l_wdata (input, DATA_WIDTH), all stable while l_req is high.
REQ-011 The module SHALL have ports l_gnt and l_rvalid, output, 1 each: loader accept pulse and loader read-data-valid pulse.
REQ-012 The module SHALL have port rdata, output, DATA_WIDTH, read data shared by both requesters, meaningful only in a cycle where f_rvalid or l_rvalid is high.
REQ-013 The module SHALL have ports ram_addr (output, ADDR_WIDTH), ram_cs, ram_we and ram_oe (output, 1 each), and ram_wdata (output, DATA_WIDTH), all registered RAM port controls.
REQ-014 The module SHALL have port ram_rdata, input, DATA_WIDTH, RAM read data, valid combinationally during an access cycle.
REQ-015 The module SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and DONE: IDLE goes to ACCESS on any granted request; ACCESS goes to DONE for a read and to IDLE for a write; DONE always goes to IDLE.
REQ-017 Arbitration SHALL occur only in IDLE; the winner's gnt SHALL be a single-cycle pulse in the same cycle, and its address, we and wdata SHALL be registered at that edge.
REQ-018 With both requests high, fetch SHALL win, except as modified by REQ-027.
REQ-019 In ACCESS, ram_cs SHALL be 1, and ram_we=1/ram_oe=0 for a write or ram_we=0/ram_oe=1 for a read.
REQ-020 ram_rdata SHALL be captured into rdata at the end of ACCESS, and the granted requester's rvalid SHALL pulse for one cycle in DONE.
REQ-021 Read latency SHALL be exactly 2 cycles from gnt to rvalid, and writes SHALL produce no rvalid.
REQ-022 Outside ACCESS, ram_cs, ram_we and ram_oe SHALL be 0, and ram_addr, ram_wdata and rdata SHALL hold their last values.
REQ-023 No request SHALL be granted in ACCESS or DONE; minimum spacing SHALL be 3 cycles between read grants and 2 cycles between write grants.
REQ-024 A request withdrawn before gnt SHALL be dropped silently.

Reset
REQ-025 Asserting rst_n low SHALL force IDLE and clear every output (gnt, rvalid, ram_cs/we/oe, busy, ram_addr, ram_wdata, rdata) and the starvation counter to 0 immediately, without waiting for a clock edge.
REQ-026 An access interrupted by reset SHALL be abandoned with no rvalid, and arbitration SHALL resume on the first clock edge after rst_n deasserts.

Configuration
REQ-027 With IMEM_ARB_STARVE_EN defined, a counter SHALL increment each time l_req loses arbitration, clear on l_gnt, and when it equals STARVE_LIMIT the loader SHALL win the next arbitration; without IMEM_ARB_STARVE_EN the counter SHALL be absent and arbitration SHALL be strict fetch priority.

Structure
REQ-028 A shared package imem_pkg SHALL hold the FSM state enum (IDLE/ACCESS/DONE) and the default width constants.
REQ-029 The priority/starvation decision SHALL be a sub-module named imem_arb_prio, and the FSM and RAM drive SHALL remain in the top module.

Verification
REQ-030 The bench SHALL check a single fetch read: f_req with f_addr=0x10 and mem[0x10]=0xBEEF -> f_gnt in cycle 0, ram_cs=1/ram_oe=1/ram_addr=0x10 in cycle 1, f_rvalid=1 with rdata=0xBEEF in cycle 2.
REQ-031 The bench SHALL check a loader write then read: write l_addr=0x05, l_wdata=0x1234 -> ram_we=1 for one cycle and no l_rvalid; a following read of 0x05 -> l_rvalid with rdata=0x1234.
REQ-032 The bench SHALL check simultaneous requests: f_req and l_req both high without the macro -> f_gnt first, and l_gnt on the next IDLE cycle after f_req drops.
REQ-033 The bench SHALL check starvation with IMEM_ARB_STARVE_EN and STARVE_LIMIT=4: f_req held high continuously -> l_gnt on the 5th arbitration, then the counter reads 0.
REQ-034 The bench SHALL check reset in ACCESS: rst_n driven low -> ram_cs=0 and busy=0 immediately, and no rvalid ever follows.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter: FSM state
// encoding and the default width/limit constants.
package imem_pkg;

  localparam int unsigned IMEM_DATA_W_DEF = 16;
  localparam int unsigned IMEM_ADDR_W_DEF = 8;
  localparam int unsigned IMEM_STARVE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_arb_prio.sv
// Fetch/loader priority decision. Fetch wins by default; with
// IMEM_ARB_STARVE_EN defined a lost-arbitration counter forces the loader.
module imem_arb_prio import imem_pkg::*; #(
  parameter int STARVE_LIMIT = IMEM_STARVE_DEF
) (
`ifdef IMEM_ARB_STARVE_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic i_arb,
  input  logic i_f_req,
  input  logic i_l_req,
  output logic o_f_win,
  output logic o_l_win
);

`ifdef IMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_l;

  assign w_force_l = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Winner selection with the starvation override
  always_comb begin
    o_l_win = i_arb & i_l_req & (w_force_l | ~i_f_req);
    o_f_win = i_arb & i_f_req & ~(w_force_l & i_l_req);
  end

  // Count arbitrations the loader loses; a loader grant clears the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (o_l_win) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (o_f_win && i_l_req) begin
      r_starve_cnt <= r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  // Strict fetch priority; the limit only matters for the override build
  if (STARVE_LIMIT < 1) begin : g_limit_unused
  end

  assign o_f_win = i_arb & i_f_req;
  assign o_l_win = i_arb & i_l_req & ~i_f_req;
`endif

endmodule

// File: rtl/imem_port_arbiter.sv
// Two-requester (fetch, loader) single-port RAM arbiter with a
// IDLE/ACCESS/DONE FSM. Optional macro: IMEM_ARB_STARVE_EN.
module imem_port_arbiter import imem_pkg::*; #(
  parameter int DATA_WIDTH   = IMEM_DATA_W_DEF,
  parameter int ADDR_WIDTH   = IMEM_ADDR_W_DEF,
  parameter int STARVE_LIMIT = IMEM_STARVE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  imem_state_e           r_state;
  imem_state_e           w_state_nxt;
  logic                  w_arb;
  logic                  w_f_win;
  logic                  w_l_win;
  logic                  w_grant;
  logic                  w_grant_wr;
  logic                  w_cs_nxt;
  logic                  w_we_nxt;
  logic                  w_oe_nxt;
  logic                  w_f_rv_nxt;
  logic                  w_l_rv_nxt;
  logic                  r_is_wr;
  logic                  r_owner_l;
  logic                  r_ram_cs;
  logic                  r_ram_we;
  logic                  r_ram_oe;
  logic                  r_f_rvalid;
  logic                  r_l_rvalid;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Gating with rst_n keeps the grant pulses low while reset is asserted
  assign w_arb = rst_n & (r_state == IDLE);

  imem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
`ifdef IMEM_ARB_STARVE_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .i_arb   (w_arb),
    .i_f_req (f_req),
    .i_l_req (l_req),
    .o_f_win (w_f_win),
    .o_l_win (w_l_win)
  );

  assign w_grant    = w_f_win | w_l_win;
  assign w_grant_wr = w_l_win & l_we;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_grant ? ACCESS : IDLE;
      ACCESS:  w_state_nxt = r_is_wr ? IDLE : DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode: next values of the registered strobes and rvalids
  always_comb begin
    w_cs_nxt   = 1'b0;
    w_we_nxt   = 1'b0;
    w_oe_nxt   = 1'b0;
    w_f_rv_nxt = 1'b0;
    w_l_rv_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cs_nxt = w_grant;
        w_we_nxt = w_grant_wr;
        w_oe_nxt = w_grant & ~w_grant_wr;
      end
      ACCESS: begin
        w_f_rv_nxt = ~r_is_wr & ~r_owner_l;
        w_l_rv_nxt = ~r_is_wr & r_owner_l;
      end
      default: begin
        w_cs_nxt = 1'b0;
      end
    endcase
  end

  // Registered RAM controls, request capture and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_oe    <= 1'b0;
      r_f_rvalid  <= 1'b0;
      r_l_rvalid  <= 1'b0;
      r_busy      <= 1'b0;
      r_is_wr     <= 1'b0;
      r_owner_l   <= 1'b0;
      r_ram_addr  <= {ADDR_WIDTH{1'b0}};
      r_ram_wdata <= {DATA_WIDTH{1'b0}};
      r_rdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      r_ram_cs   <= w_cs_nxt;
      r_ram_we   <= w_we_nxt;
      r_ram_oe   <= w_oe_nxt;
      r_f_rvalid <= w_f_rv_nxt;
      r_l_rvalid <= w_l_rv_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      if (w_grant) begin
        r_ram_addr <= w_l_win ? l_addr : f_addr;
        r_is_wr    <= w_grant_wr;
        r_owner_l  <= w_l_win;
        if (w_grant_wr) begin
          r_ram_wdata <= l_wdata;
        end
      end
      if ((r_state == ACCESS) && !r_is_wr) begin
        r_rdata <= ram_rdata;
      end
    end
  end

  assign f_gnt     = w_f_win;
  assign l_gnt     = w_l_win;
  assign f_rvalid  = r_f_rvalid;
  assign l_rvalid  = r_l_rvalid;
  assign rdata     = r_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_cs    = r_ram_cs;
  assign ram_we    = r_ram_we;
  assign ram_oe    = r_ram_oe;
  assign ram_wdata = r_ram_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a behavioural RAM.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic        l_req;
  logic        l_we;
  logic [7:0]  l_addr;
  logic [15:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [15:0] rdata;
  logic [7:0]  ram_addr;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [256];

  imem_port_arbiter #(
    .DATA_WIDTH   (16),
    .ADDR_WIDTH   (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the edge closing ACCESS
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    else if (!rst_n) mem[8'h10] <= 16'hBEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = 8'h00;
    l_req = 1'b0; l_we = 1'b0; l_addr = 8'h00; l_wdata = 16'h0000;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cs", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
    chk("rst_rvalid", 32'({f_rvalid, l_rvalid}), 32'd0);
    chk("rst_data", 32'({ram_addr, ram_wdata, rdata}), 32'd0);
    f_req = 1'b1; #1;
    chk("rst_gnt_gated", 32'({f_gnt, l_gnt}), 32'd0);
    f_req = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Single fetch read of 0x10
    f_req = 1'b1; f_addr = 8'h10; #1;
    chk("fr_gnt", 32'({f_gnt, l_gnt}), 32'b10);
    chk("fr_busy0", 32'(busy), 32'd0);
    cyc(); f_req = 1'b0;
    chk("fr_c1_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
    chk("fr_c1_addr", 32'(ram_addr), 32'h10);
    chk("fr_c1_rvalid", 32'(f_rvalid), 32'd0);
    chk("fr_c1_busy", 32'(busy), 32'd1);
    cyc();
    chk("fr_c2_rvalid", 32'({f_rvalid, l_rvalid}), 32'b10);
    chk("fr_c2_rdata", 32'(rdata), 32'hBEEF);
    chk("fr_c2_cs", 32'(ram_cs), 32'd0);
    chk("fr_c2_nogrant", 32'(f_gnt), 32'd0);
    cyc();
    chk("fr_c3_idle", 32'({busy, f_rvalid}), 32'd0);
    chk("fr_c3_hold", 32'({ram_addr, rdata}), 32'h10BEEF);

    // Loader write 0x1234 to 0x05, then read it back
    l_req = 1'b1; l_we = 1'b1; l_addr = 8'h05; l_wdata = 16'h1234; #1;
    chk("lw_gnt", 32'({f_gnt, l_gnt}), 32'b01);
    cyc(); l_req = 1'b0;
    chk("lw_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'b110);
    chk("lw_addr_data", 32'({ram_addr, ram_wdata}), 32'h051234);
    cyc();
    chk("lw_done", 32'({ram_cs, ram_we, l_rvalid, busy}), 32'd0);
    l_req = 1'b1; l_we = 1'b0; #1;
    chk("lr_gnt_spacing2", 32'(l_gnt), 32'd1);
    cyc(); l_req = 1'b0;
    chk("lr_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
    cyc();
    chk("lr_rvalid", 32'({f_rvalid, l_rvalid}), 32'b01);
    chk("lr_rdata", 32'(rdata), 32'h1234);
    cyc();
    chk("lr_norvalid", 32'(l_rvalid), 32'd0);

    // Simultaneous requests: fetch first, loader after fetch drops
    f_req = 1'b1; f_addr = 8'h10; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h05; #1;
    chk("sim_gnt0", 32'({f_gnt, l_gnt}), 32'b10);
    cyc(); f_req = 1'b0;
    chk("sim_access_nogrant", 32'(l_gnt), 32'd0);
    cyc();
    chk("sim_done_nogrant", 32'(l_gnt), 32'd0);
    chk("sim_f_rdata", 32'({f_rvalid, rdata}), 32'h1BEEF);
    cyc();
    chk("sim_gnt1", 32'({f_gnt, l_gnt}), 32'b01);
    cyc(); l_req = 1'b0;
    cyc();
    chk("sim_l_rdata", 32'({l_rvalid, rdata}), 32'h11234);
    cyc();

`ifdef IMEM_ARB_STARVE_EN
    // Fetch held continuously: loader forced on the 5th arbitration
    f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h05;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("stv_cnt_before", 32'(dut.u_prio.r_starve_cnt), 32'(k - 1));
      chk("stv_f_gnt", 32'(f_gnt), (k < 5) ? 32'd1 : 32'd0);
      chk("stv_l_gnt", 32'(l_gnt), (k == 5) ? 32'd1 : 32'd0);
      cyc();
      if (k == 5) begin
        l_req = 1'b0;
        chk("stv_cnt_cleared", 32'(dut.u_prio.r_starve_cnt), 32'd0);
      end
      cyc(); cyc();
    end
    f_req = 1'b0;
    cyc();
`endif

    // Reset asserted mid-ACCESS: immediate clear, no rvalid afterwards
    f_req = 1'b1; f_addr = 8'h10; #1;
    chk("ra_gnt", 32'(f_gnt), 32'd1);
    cyc(); f_req = 1'b0;
    chk("ra_in_access", 32'(ram_cs), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("ra_cs_cleared", 32'({ram_cs, ram_oe}), 32'd0);
    chk("ra_busy_cleared", 32'(busy), 32'd0);
    chk("ra_addr_cleared", 32'(ram_addr), 32'd0);
    cyc();
    chk("ra_no_rvalid_r", 32'({f_rvalid, l_rvalid}), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ra_no_rvalid", 32'({f_rvalid, l_rvalid, busy}), 32'd0);
    end
    f_req = 1'b1; f_addr = 8'h10; #1;
    chk("ra_resume_gnt", 32'(f_gnt), 32'd1);
    cyc(); f_req = 1'b0;
    cyc();
    chk("ra_resume_read", 32'({f_rvalid, rdata}), 32'h1BEEF);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
